// File: rtl/mem_bus_master_if.sv
// Core request/response port and 10-bit multiplexed memory bus of mem_bus_master.
// The master modport is the initiator block; slave is the core driver plus memory.
interface mem_bus_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              wr_err;
    logic              read_write;
    logic              write_commit;
    logic              dump_mem;
    logic [ADDR_W-1:0] addr_data;
    logic [DATA_W-1:0] mem_result;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, mem_result,
        output req_ready, resp_valid, resp_rdata, wr_err,
               read_write, write_commit, dump_mem, addr_data
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, mem_result,
        input  req_ready, resp_valid, resp_rdata, wr_err,
               read_write, write_commit, dump_mem, addr_data
    );
endinterface

// File: rtl/mem_bus_master.sv
// Sequences core requests into multiplexed memory bus cycles; MEM_BUS_WRITE_VERIFY_EN adds a write read-back.
// Response 1 cycle after the last bus cycle (read 1, write 3 or 4, dump 1, nop 0); req_ready only in IDLE, no response backpressure.
module mem_bus_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int HALF_W = DATA_W / 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_master_if.master    bus
);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_DMP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WA,
        S_WL,
        S_WH,
        S_DMP
`ifdef MEM_BUS_WRITE_VERIFY_EN
        , S_VF
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              accept;
    logic [DATA_W-1:0] wdata_q;

    logic              rw_q;
    logic              wc_q;
    logic              dm_q;
    logic [ADDR_W-1:0] ad_q;
    logic              rv_q;
    logic [DATA_W-1:0] rd_q;

    logic              rw_nxt;
    logic              wc_nxt;
    logic              dm_nxt;
    logic [ADDR_W-1:0] ad_nxt;
    logic              rv_nxt;
    logic [DATA_W-1:0] rd_nxt;

`ifdef MEM_BUS_WRITE_VERIFY_EN
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              err_nxt;
`endif

    assign bus.req_ready = (state == S_IDLE);
    assign accept        = bus.req_valid && (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are the registered image of the next state's bus pattern, so the
    // bus changes exactly at the edge that enters each state.
    always_comb begin
        state_nxt = state;
        rw_nxt    = 1'b1;
        wc_nxt    = 1'b0;
        dm_nxt    = 1'b0;
        ad_nxt    = '0;
        rv_nxt    = 1'b0;
        rd_nxt    = '0;
`ifdef MEM_BUS_WRITE_VERIFY_EN
        err_nxt   = err_q;
`endif
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_RD: begin
                            state_nxt = S_RD;
                            ad_nxt    = bus.req_addr;
                        end
                        OP_WR: begin
                            state_nxt = S_WA;
                            rw_nxt    = 1'b0;
                            ad_nxt    = bus.req_addr;
                        end
                        OP_DMP: begin
                            state_nxt = S_DMP;
                            dm_nxt    = 1'b1;
                        end
                        default: begin
                            rv_nxt    = 1'b1;
                        end
                    endcase
                end
            end
            S_RD: begin
                state_nxt = S_IDLE;
                rv_nxt    = 1'b1;
                rd_nxt    = bus.mem_result;
            end
            S_WA: begin
                state_nxt              = S_WL;
                rw_nxt                 = 1'b0;
                wc_nxt                 = 1'b1;
                ad_nxt[HALF_W]         = 1'b0;
                ad_nxt[HALF_W-1:0]     = wdata_q[HALF_W-1:0];
            end
            S_WL: begin
                state_nxt              = S_WH;
                rw_nxt                 = 1'b0;
                wc_nxt                 = 1'b1;
                ad_nxt[HALF_W]         = 1'b1;
                ad_nxt[HALF_W-1:0]     = wdata_q[DATA_W-1:HALF_W];
            end
            S_WH: begin
`ifdef MEM_BUS_WRITE_VERIFY_EN
                state_nxt = S_VF;
                ad_nxt    = addr_q;
`else
                state_nxt = S_IDLE;
                rv_nxt    = 1'b1;
`endif
            end
`ifdef MEM_BUS_WRITE_VERIFY_EN
            S_VF: begin
                state_nxt = S_IDLE;
                rv_nxt    = 1'b1;
                rd_nxt    = bus.mem_result;
                if (bus.mem_result != wdata_q) begin
                    err_nxt = 1'b1;
                end
            end
`endif
            S_DMP: begin
                state_nxt = S_IDLE;
                rv_nxt    = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q    <= 1'b1;
            wc_q    <= 1'b0;
            dm_q    <= 1'b0;
            ad_q    <= '0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            rw_q    <= rw_nxt;
            wc_q    <= wc_nxt;
            dm_q    <= dm_nxt;
            ad_q    <= ad_nxt;
            rv_q    <= rv_nxt;
            rd_q    <= rd_nxt;
            if (accept) begin
                wdata_q <= bus.req_wdata;
            end
        end
    end

`ifdef MEM_BUS_WRITE_VERIFY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= err_nxt;
            if (accept) begin
                addr_q <= bus.req_addr;
            end
        end
    end

    assign bus.wr_err = err_q;
`else
    assign bus.wr_err = 1'b0;
`endif

    assign bus.read_write   = rw_q;
    assign bus.write_commit = wc_q;
    assign bus.dump_mem     = dm_q;
    assign bus.addr_data    = ad_q;
    assign bus.resp_valid   = rv_q;
    assign bus.resp_rdata   = rd_q;

endmodule
